// File: rtl/latch_bank_arbiter_if.sv
// Requester and latch-bank signal bundle for latch_bank_arbiter.
// The slave modport is the arbiter; the master modport is the requesters plus the latch bank.
interface latch_bank_arbiter_if #(
  parameter int NREQ = 4,
  parameter int NLAT = 4,
  parameter int AW   = 2,
  parameter int DW   = 8
);
  logic [NREQ-1:0]    req;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    gnt;
  logic [NREQ-1:0]    done;
  logic               busy;
  logic [DW-1:0]      lat_data;
  logic [NLAT-1:0]    lat_en;
  logic [NLAT*DW-1:0] lat_q;
  logic               err;

  modport master (
    output req, req_addr, req_data, lat_q,
    input  gnt, done, busy, lat_data, lat_en, err
  );

  modport slave (
    input  req, req_addr, req_data, lat_q,
    output gnt, done, busy, lat_data, lat_en, err
  );
endinterface

// File: rtl/latch_bank_arbiter.sv
// Round-robin arbiter that sequences one write at a time into a shared latch bank.
// Each write runs setup -> open -> hold. Define LATCH_READBACK_EN to check lat_q in hold and drive a sticky err.
module latch_bank_arbiter #(
  parameter int NREQ     = 4,
  parameter int NLAT     = 4,
  parameter int AW       = 2,
  parameter int DW       = 8,
  parameter int OPEN_CYC = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  latch_bank_arbiter_if.slave bus
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = (OPEN_CYC > 1) ? $clog2(OPEN_CYC) : 1;

  typedef enum logic [1:0] {IDLE, SETUP, OPEN, HOLD} state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [NREQ-1:0] done_q, done_d;
  logic            busy_q, busy_d;
  logic [DW-1:0]   lat_data_q, lat_data_d;
  logic [NLAT-1:0] lat_en_q, lat_en_d;
  logic            err_q, err_d;
  logic            err_set;

  logic            win_found;
  logic [IW-1:0]   win_idx;
  logic [IW-1:0]   scan_idx;

  // Scan requesters starting at the pointer, wrapping modulo NREQ.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan_idx  = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      scan_idx = IW'((32'(ptr_q) + i) % NREQ);
      if (!win_found && bus.req[scan_idx]) begin
        win_found = 1'b1;
        win_idx   = scan_idx;
      end
    end
  end

`ifdef LATCH_READBACK_EN
  logic          rb_hit;
  logic          rb_bad;
  logic [DW-1:0] rb_word;

  always_comb begin
    rb_hit  = 1'b0;
    rb_bad  = 1'b0;
    rb_word = '0;
    for (int unsigned i = 0; i < NLAT; i++) begin
      if (addr_q == AW'(i)) begin
        rb_hit  = 1'b1;
        rb_word = DW'(bus.lat_q >> (i * DW));
        rb_bad  = (rb_word != lat_data_q);
      end
    end
  end

  assign err_set = (state_q == HOLD) && (!rb_hit || rb_bad);
`else
  assign err_set = 1'b0;
`endif

  // Outputs are decoded from the next state so every output is a register.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    ptr_d      = ptr_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    lat_data_d = lat_data_q;
    err_d      = err_q | err_set;

    case (state_q)
      IDLE: begin
        if (win_found) begin
          state_d    = SETUP;
          idx_d      = win_idx;
          addr_d     = AW'(bus.req_addr >> (32'(win_idx) * AW));
          lat_data_d = DW'(bus.req_data >> (32'(win_idx) * DW));
        end
      end
      SETUP: begin
        state_d = OPEN;
        cnt_d   = '0;
      end
      OPEN: begin
        if (cnt_q == CW'(OPEN_CYC - 1)) state_d = HOLD;
        else                            cnt_d   = cnt_q + 1'b1;
      end
      HOLD: begin
        state_d = IDLE;
        ptr_d   = (idx_q == IW'(NREQ - 1)) ? '0 : idx_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
    for (int unsigned i = 0; i < NREQ; i++) begin
      gnt_d[i]  = (state_d != IDLE) && (idx_d == IW'(i));
      done_d[i] = (state_d == HOLD) && (idx_d == IW'(i));
    end
    for (int unsigned i = 0; i < NLAT; i++) begin
      lat_en_d[i] = (state_d == OPEN) && (addr_d == AW'(i));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      ptr_q      <= '0;
      addr_q     <= '0;
      cnt_q      <= '0;
      gnt_q      <= '0;
      done_q     <= '0;
      busy_q     <= 1'b0;
      lat_data_q <= '0;
      lat_en_q   <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      ptr_q      <= ptr_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      gnt_q      <= gnt_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
      lat_data_q <= lat_data_d;
      lat_en_q   <= lat_en_d;
      err_q      <= err_d;
    end
  end

  assign bus.gnt      = gnt_q;
  assign bus.done     = done_q;
  assign bus.busy     = busy_q;
  assign bus.lat_data = lat_data_q;
  assign bus.lat_en   = lat_en_q;
  assign bus.err      = err_q;
endmodule

// File: tb/tb_latch_bank_arbiter.sv
// Bench for latch_bank_arbiter: timeline model checked every cycle, plus directed literal checks.
`timescale 1ns/1ps
module tb_latch_bank_arbiter;
  localparam int NREQ = 4;
  localparam int NLAT = 4;
  localparam int AW   = 2;
  localparam int DW   = 8;
  localparam int OC   = 1;
`ifdef LATCH_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  latch_bank_arbiter_if #(.NREQ(NREQ), .NLAT(NLAT), .AW(AW), .DW(DW)) bus ();
  latch_bank_arbiter_if #(.NREQ(NREQ), .NLAT(3),    .AW(AW), .DW(DW)) bus3 ();

  latch_bank_arbiter #(.NREQ(NREQ), .NLAT(NLAT), .AW(AW), .DW(DW), .OPEN_CYC(OC)) u_dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
  latch_bank_arbiter #(.NREQ(NREQ), .NLAT(3), .AW(AW), .DW(DW), .OPEN_CYC(OC)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .bus(bus3)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Latch bank environment; latch 1 of the main bank can be forced stuck at zero.
  logic [DW-1:0] mem  [NLAT] = '{default: '0};
  logic [DW-1:0] mem3 [3]    = '{default: '0};
  bit            stuck1      = 1'b0;
  always @(negedge clk) begin
    for (int i = 0; i < NLAT; i++)
      if (bus.lat_en[i]) mem[i] <= (stuck1 && i == 1) ? '0 : bus.lat_data;
    for (int i = 0; i < 3; i++)
      if (bus3.lat_en[i]) mem3[i] <= bus3.lat_data;
  end
  assign bus.lat_q  = {mem[3], mem[2], mem[1], mem[0]};
  assign bus3.lat_q = {mem3[2], mem3[1], mem3[0]};

  // Timeline model: a write won at edge T occupies cycles k=1..2+OC after it.
  bit            m_active;
  int            m_k, m_w, m_addr, m_ptr;
  logic [DW-1:0] m_ld;
  bit            m_err;

  task automatic m_reset();
    m_active = 1'b0; m_k = 0; m_w = 0; m_addr = 0; m_ptr = 0; m_ld = '0; m_err = 1'b0;
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_reset();
      end else if (m_active) begin
        if (m_k == 2 + OC) begin
          m_active = 1'b0;
          m_ptr    = (m_w + 1) % NREQ;
          if (RB && ((m_addr >= NLAT) || (bus.lat_q[m_addr*DW +: DW] != m_ld))) m_err = 1'b1;
        end else begin
          m_k++;
        end
      end else begin
        for (int i = 0; i < NREQ; i++) begin
          int j;
          j = (m_ptr + i) % NREQ;
          if (!m_active && bus.req[j]) begin
            m_active = 1'b1;
            m_k      = 1;
            m_w      = j;
            m_addr   = int'(bus.req_addr[j*AW +: AW]);
            m_ld     = bus.req_data[j*DW +: DW];
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    check("gnt",      32'(bus.gnt),      m_active ? (32'd1 << m_w) : 32'd0);
    check("done",     32'(bus.done),     (m_active && m_k == 2 + OC) ? (32'd1 << m_w) : 32'd0);
    check("busy",     32'(bus.busy),     32'(m_active));
    check("lat_en",   32'(bus.lat_en),
          (m_active && m_k >= 2 && m_k <= 1 + OC && m_addr < NLAT) ? (32'd1 << m_addr) : 32'd0);
    check("lat_data", 32'(bus.lat_data), 32'(m_ld));
    check("err",      32'(bus.err),      32'(m_err));
  end

  task automatic set_req(input int i, input int a, input logic [DW-1:0] d);
    bus.req_addr[i*AW +: AW] = AW'(a);
    bus.req_data[i*DW +: DW] = d;
    bus.req[i]               = 1'b1;
  endtask

  task automatic wait_done(input int bound);
    int c = 0;
    while (bus.done == '0 && c < bound) begin
      @(negedge clk);
      c++;
    end
    check("done_seen", 32'(|bus.done), 32'd1);
  endtask

  task automatic wait_en(input int bound);
    int c = 0;
    while (bus.lat_en == '0 && c < bound) begin
      @(negedge clk);
      c++;
    end
    check("lat_en_seen", 32'(|bus.lat_en), 32'd1);
  endtask

  initial begin
    int            order [5] = '{0, 1, 2, 3, 0};
    logic [DW-1:0] t3d   [5] = '{8'h10, 8'h21, 8'h32, 8'h43, 8'h10};
    int            prev;
    bit            seen;

    bus.req = '0; bus.req_addr = '0; bus.req_data = '0;
    bus3.req = '0; bus3.req_addr = '0; bus3.req_data = '0;

    repeat (3) @(negedge clk);
    check("rst_busy",   32'(bus.busy),     32'd0);
    check("rst_gnt",    32'(bus.gnt),      32'd0);
    check("rst_lat_en", 32'(bus.lat_en),   32'd0);
    check("rst_data",   32'(bus.lat_data), 32'd0);
    rst_n = 1'b1;

    // Round-robin with all requests held
    @(negedge clk);
    set_req(0, 0, 8'h10); set_req(1, 1, 8'h21); set_req(2, 2, 8'h32); set_req(3, 3, 8'h43);
    prev = 0;
    for (int n = 0; n < 5; n++) begin
      wait_done(12);
      check("rr_order", 32'(bus.done),     32'd1 << order[n]);
      check("rr_data",  32'(bus.lat_data), 32'(t3d[n]));
      if (n > 0) check("rr_spacing", 32'(cyc - prev), 32'd4);
      prev = cyc;
      if (n == 4) bus.req = '0;
      @(negedge clk);
    end

    // Single write timeline
    set_req(1, 3, 8'hA5);
    @(negedge clk);
    check("w_gnt_t1",  32'(bus.gnt),      32'b0010);
    check("w_en_t1",   32'(bus.lat_en),   32'd0);
    check("w_data_t1", 32'(bus.lat_data), 32'hA5);
    @(negedge clk);
    check("w_en_t2",   32'(bus.lat_en),   32'b1000);
    check("w_data_t2", 32'(bus.lat_data), 32'hA5);
    @(negedge clk);
    check("w_done_t3", 32'(bus.done),     32'b0010);
    check("w_en_t3",   32'(bus.lat_en),   32'd0);
    check("w_data_t3", 32'(bus.lat_data), 32'hA5);
    bus.req[1] = 1'b0;
    @(negedge clk);
    check("w_gnt_idle",  32'(bus.gnt),      32'd0);
    check("w_busy_idle", 32'(bus.busy),     32'd0);
    check("w_data_idle", 32'(bus.lat_data), 32'hA5);
    check("w_mem3",      32'(mem[3]),       32'hA5);

    // Fairness: serve req[2], then req=0101 must go 0 then 2
    set_req(2, 2, 8'h5C);
    wait_done(8);
    check("fair_first", 32'(bus.done), 32'b0100);
    set_req(0, 0, 8'h01); set_req(2, 1, 8'h02);
    @(negedge clk);
    wait_done(8);
    check("fair_second", 32'(bus.done), 32'b0001);
    bus.req[0] = 1'b0;
    @(negedge clk);
    wait_done(8);
    check("fair_third", 32'(bus.done), 32'b0100);
    bus.req[2] = 1'b0;
    @(negedge clk);

    // Inputs changed and req dropped during OPEN
    set_req(3, 0, 8'h77);
    wait_en(8);
    check("mid_en", 32'(bus.lat_en), 32'b0001);
    bus.req_data[3*DW +: DW] = 8'hFF;
    bus.req_addr[3*AW +: AW] = 2'd2;
    bus.req[3] = 1'b0;
    wait_done(8);
    check("mid_done", 32'(bus.done),     32'b1000);
    check("mid_data", 32'(bus.lat_data), 32'h77);
    @(negedge clk);
    check("mid_mem0", 32'(mem[0]), 32'h77);

    // Async reset in the middle of OPEN
    set_req(0, 1, 8'h42);
    wait_en(8);
    #2 rst_n = 1'b0;
    #1;
    check("ar_lat_en", 32'(bus.lat_en), 32'd0);
    check("ar_done",   32'(bus.done),   32'd0);
    check("ar_busy",   32'(bus.busy),   32'd0);
    bus.req[0] = 1'b0;
    set_req(2, 2, 8'h5A);
    @(negedge clk);
    rst_n = 1'b1;
    wait_done(8);
    check("ar_winner", 32'(bus.done),     32'b0100);
    check("ar_data",   32'(bus.lat_data), 32'h5A);
    bus.req[2] = 1'b0;
    @(negedge clk);

    // Out-of-range address on the three-latch instance
    bus3.req_addr[1*AW +: AW] = 2'd3;
    bus3.req_data[1*DW +: DW] = 8'h3C;
    bus3.req[1] = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check("oor_lat_en", 32'(bus3.lat_en), 32'd0);
      if (bus3.done[1]) begin
        seen = 1'b1;
        bus3.req[1] = 1'b0;
      end
    end
    check("oor_done", 32'(seen),     32'd1);
    check("oor_err",  32'(bus3.err), 32'(RB));

    // Stuck latch readback
    stuck1 = 1'b1;
    set_req(1, 1, 8'h3C);
    wait_done(8);
    check("rb_data", 32'(bus.lat_data), 32'h3C);
    bus.req[1] = 1'b0;
    @(negedge clk);
    check("rb_err", 32'(bus.err), 32'(RB));
    repeat (3) @(negedge clk);
    check("rb_err_sticky", 32'(bus.err), 32'(RB));
    #2 rst_n = 1'b0;
    #1;
    check("rb_err_clr",  32'(bus.err),  32'd0);
    check("rb_err3_clr", 32'(bus3.err), 32'd0);
    stuck1 = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
